// File: rtl/tty_pkg.sv
// Shared types and constants for the text-mode terminal writer.
// Holds the FSM state encoding, the handled control codes and the default fill byte.
package tty_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PUT,
      SCROLL_RD,
      SCROLL_WR,
      CLEAR_ROW,
      CLEAR_ALL
   } state_t;

   localparam logic [7:0] CH_BS = 8'h08;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_FF = 8'h0C;
   localparam logic [7:0] CH_CR = 8'h0D;

   localparam int         COLS          = 32;
   localparam logic [7:0] BLANK_DEFAULT = 8'h20;

endpackage

// File: rtl/tty_writer.sv
// Character stream to 32-column text page writer: printable byte written one cycle after acceptance,
// scroll costs two cycles per copied byte plus 32 for the blank row; in_ready is low whenever not IDLE.
module tty_writer
   import tty_pkg::*;
#(
   parameter int         ROWS  = 24,
   parameter logic [7:0] BLANK = BLANK_DEFAULT
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [9:0] ram_address,
   output logic [7:0] ram_wdata,
   output logic       ram_we,
   input  logic [7:0] ram_rdata,
   output logic [4:0] cursor_col,
   output logic [4:0] cursor_row,
   output logic       busy
);

   localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
   localparam logic [4:0] LAST_COL  = 5'(COLS - 1);
   localparam logic [9:0] LAST_ADDR = 10'(ROWS * COLS - 1);
   localparam logic [9:0] ROW_BYTES = 10'(COLS);
   // A single-row screen has nothing to copy, so scrolling starts at the blanking phase.
   localparam state_t     SCROLL_ENTRY = (ROWS == 1) ? CLEAR_ROW : SCROLL_RD;
   localparam logic [9:0] SCROLL_IDX   = (ROWS == 1) ? 10'd0 : ROW_BYTES;

   state_t     state, state_nx;
   logic [9:0] idx, idx_nx;
   logic [4:0] col, col_nx;
   logic [4:0] row, row_nx;
   logic [7:0] put_byte, put_byte_nx;
   logic       scroll_pend, scroll_pend_nx;
   logic       we_c;
   logic       accept;

   assign in_ready   = (state == IDLE);
   assign busy       = (state != IDLE);
   assign accept     = in_valid && in_ready;
   assign cursor_col = col;
   assign cursor_row = row;
   // Reset holds the FSM in CLEAR_ALL; gating keeps the strobe quiet until release.
   assign ram_we     = we_c && reset_n;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= CLEAR_ALL;
         idx         <= '0;
         col         <= '0;
         row         <= '0;
         put_byte    <= BLANK;
         scroll_pend <= 1'b0;
      end else begin
         state       <= state_nx;
         idx         <= idx_nx;
         col         <= col_nx;
         row         <= row_nx;
         put_byte    <= put_byte_nx;
         scroll_pend <= scroll_pend_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      idx_nx         = idx;
      col_nx         = col;
      row_nx         = row;
      put_byte_nx    = put_byte;
      scroll_pend_nx = scroll_pend;
      we_c           = 1'b0;
      ram_address    = idx;
      ram_wdata      = BLANK;

      case (state)
         IDLE: begin
            if (accept) begin
               if (in_data >= 8'h20) begin
                  // Cursor moves at acceptance; idx carries the target cell into PUT.
                  state_nx    = PUT;
                  idx_nx      = {row, col};
                  put_byte_nx = in_data;
                  if (col != LAST_COL) begin
                     col_nx = col + 5'd1;
                  end else begin
                     col_nx = '0;
                     if (row != LAST_ROW) row_nx = row + 5'd1;
                     else scroll_pend_nx = 1'b1;
                  end
               end else begin
                  case (in_data)
                     CH_CR: col_nx = '0;
                     CH_LF: begin
                        col_nx = '0;
                        if (row != LAST_ROW) begin
                           row_nx = row + 5'd1;
                        end else begin
                           state_nx = SCROLL_ENTRY;
                           idx_nx   = SCROLL_IDX;
                        end
                     end
                     CH_BS: if (col != '0) col_nx = col - 5'd1;
                     CH_FF: begin
                        state_nx = CLEAR_ALL;
                        idx_nx   = '0;
                        col_nx   = '0;
                        row_nx   = '0;
                     end
                     default: ;
                  endcase
               end
            end
         end

         PUT: begin
            we_c      = 1'b1;
            ram_wdata = put_byte;
            if (scroll_pend) begin
               state_nx       = SCROLL_ENTRY;
               idx_nx         = SCROLL_IDX;
               scroll_pend_nx = 1'b0;
            end else begin
               state_nx = IDLE;
            end
         end

         SCROLL_RD: begin
            state_nx = SCROLL_WR;
         end

         SCROLL_WR: begin
            we_c        = 1'b1;
            ram_address = idx - ROW_BYTES;
            ram_wdata   = ram_rdata;
            if (idx == LAST_ADDR) begin
               state_nx = CLEAR_ROW;
               idx_nx   = '0;
            end else begin
               state_nx = SCROLL_RD;
               idx_nx   = idx + 10'd1;
            end
         end

         CLEAR_ROW: begin
            we_c        = 1'b1;
            ram_address = {LAST_ROW, idx[4:0]};
            if (idx[4:0] == LAST_COL) begin
               state_nx = IDLE;
               idx_nx   = '0;
            end else begin
               idx_nx = idx + 10'd1;
            end
         end

         CLEAR_ALL: begin
            we_c = 1'b1;
            if (idx == LAST_ADDR) begin
               state_nx = IDLE;
               idx_nx   = '0;
            end else begin
               idx_nx = idx + 10'd1;
            end
         end

         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_tty_writer.sv
// Scoreboard bench for tty_writer: expected RAM writes are queued by the stimulus
// and matched in order by a monitor sampling on the falling clock edge.
module tb_tty_writer;

   localparam int ROWS = 24;

   typedef struct {
      logic [9:0] addr;
      logic [7:0] data;
   } wr_t;

   logic       clock;
   logic       reset_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [9:0] ram_address;
   logic [7:0] ram_wdata;
   logic       ram_we;
   logic [7:0] ram_rdata;
   logic [4:0] cursor_col;
   logic [4:0] cursor_row;
   logic       busy;

   logic [7:0] mem [1024];
   wr_t        exp_q [$];
   int         checks = 0;
   int         fails  = 0;

   tty_writer #(.ROWS(ROWS), .BLANK(8'h20)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .ram_address (ram_address),
      .ram_wdata   (ram_wdata),
      .ram_we      (ram_we),
      .ram_rdata   (ram_rdata),
      .cursor_col  (cursor_col),
      .cursor_row  (cursor_row),
      .busy        (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous-read text RAM
   always @(posedge clock) begin
      ram_rdata <= mem[ram_address];
      if (ram_we) mem[ram_address] = ram_wdata;
   end

   // Write monitor
   always @(negedge clock) begin
      if (ram_we) begin
         checks++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: got addr=%0d data=%02h, required no write", ram_address, ram_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (ram_address !== e.addr || ram_wdata !== e.data || ram_address[9:5] >= 5'(ROWS)) begin
               fails++;
               $display("FAIL ram_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                        ram_address, ram_wdata, e.addr, e.data);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push(input logic [9:0] a, input logic [7:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic push_clear_all();
      for (int a = 0; a < ROWS * 32; a++) push(10'(a), 8'h20);
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clock);
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 5000) begin
         @(negedge clock);
         n++;
      end
      if (n >= 5000) begin
         checks++;
         fails++;
         $display("FAIL send_timeout: in_ready stayed 0, required 1");
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int start, input int req);
      int n;
      int guard;
      n = start;
      guard = 0;
      forever begin
         @(negedge clock);
         if (in_ready) break;
         n++;
         guard++;
         if (guard > 5000) break;
      end
      chk(name, 32'(n), 32'(req));
   endtask

   task automatic chk_cursor(input string name, input int r, input int c);
      chk({name, "_row"}, 32'(cursor_row), 32'(r));
      chk({name, "_col"}, 32'(cursor_col), 32'(c));
   endtask

   initial begin
      int n;
      reset_n  = 1'b0;
      in_data  = 8'h00;
      in_valid = 1'b0;
      for (int a = 0; a < 1024; a++) mem[a] = 8'hEE;
      repeat (3) @(negedge clock);

      // Reset state
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_addr", 32'(ram_address), 32'd0);
      chk("rst_wdata", 32'(ram_wdata), 32'h20);
      chk_cursor("rst", 0, 0);

      // Power-up clear
      push_clear_all();
      @(posedge clock);
      #2 reset_n = 1'b1;
      wait_idle("init_clear_cycles", 0, 768);
      chk("init_clear_drained", 32'(exp_q.size()), 32'd0);
      chk_cursor("init", 0, 0);

      // Single printable
      push(10'd0, 8'h41);
      send(8'h41);
      chk("a_busy", 32'(busy), 32'd1);
      chk_cursor("a", 0, 1);
      wait_idle("a_busy_cycles", 0, 1);

      // Line wrap with 33 characters
      send(CR_BYTE());
      for (int i = 0; i < 33; i++) push(10'(i), 8'h42);
      for (int i = 0; i < 33; i++) send(8'h42);
      wait_idle("b_idle", 0, 1);
      chk_cursor("b", 1, 1);

      // Move to (23,5)
      send(CR_BYTE());
      for (int i = 0; i < 22; i++) send(8'h0A);
      chk_cursor("lf22", 23, 0);
      for (int i = 0; i < 5; i++) push(10'(736 + i), 8'h45);
      for (int i = 0; i < 5; i++) send(8'h45);
      wait_idle("e_idle", 0, 1);
      chk_cursor("e", 23, 5);

      // Scroll with row-tagged content; in_valid pulses while busy must be ignored
      for (int a = 0; a < 768; a++) mem[a] = 8'(a >> 5);
      for (int a = 32; a < 768; a++) push(10'(a - 32), 8'(a >> 5));
      for (int c = 0; c < 32; c++) push(10'(736 + c), 8'h20);
      send(8'h0A);
      chk_cursor("scroll", 23, 0);
      n = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         if (busy) n++;
         in_data  = 8'h58;
         in_valid = 1'b1;
      end
      @(negedge clock);
      if (busy) n++;
      in_valid = 1'b0;
      wait_idle("scroll_cycles", n, 736 * 2 + 32);
      chk("scroll_drained", 32'(exp_q.size()), 32'd0);
      chk_cursor("scroll_end", 23, 0);

      // Control codes: BS at col 0, CR, ignored BEL, FF
      send(8'h08);
      chk_cursor("bs0", 23, 0);
      send(8'h0D);
      chk("cr_busy", 32'(busy), 32'd0);
      send(8'h07);
      chk("bel_busy", 32'(busy), 32'd0);
      chk_cursor("bel", 23, 0);
      push_clear_all();
      send(8'h0C);
      chk_cursor("ff", 0, 0);
      chk("ff_busy", 32'(busy), 32'd1);
      wait_idle("ff_cycles", 0, 768);
      chk("ff_drained", 32'(exp_q.size()), 32'd0);

      // Backspace mid-line overwrites without erasing
      push(10'd0, 8'h43);
      push(10'd1, 8'h43);
      send(8'h43);
      send(8'h43);
      send(8'h08);
      chk_cursor("bs1", 0, 1);
      push(10'd1, 8'h44);
      send(8'h44);
      chk_cursor("d", 0, 2);

      // Reset during scroll
      send(8'h0D);
      for (int i = 0; i < 23; i++) send(8'h0A);
      chk_cursor("pre_abort", 23, 0);
      for (int a = 32; a < 768; a++) push(10'(a - 32), 8'h20);
      for (int c = 0; c < 32; c++) push(10'(736 + c), 8'h20);
      send(8'h0A);
      repeat (100) @(negedge clock);
      chk("abort_started", 32'(exp_q.size() < 768), 32'd1);
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_we", 32'(ram_we), 32'd0);
      chk("abort_addr", 32'(ram_address), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      chk_cursor("abort", 0, 0);
      exp_q.delete();
      repeat (3) @(negedge clock);
      push_clear_all();
      @(posedge clock);
      #2 reset_n = 1'b1;
      wait_idle("restart_clear_cycles", 0, 768);
      chk("restart_drained", 32'(exp_q.size()), 32'd0);
      chk_cursor("restart", 0, 0);

      repeat (4) @(negedge clock);
      chk("final_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   function automatic logic [7:0] CR_BYTE();
      return 8'h0D;
   endfunction

endmodule
